// File: rtl/alu_result_buffer_if.sv
// Handshake bundle for the ALU result buffer.
// Upstream result push side and downstream head/pop side.
interface alu_result_buffer_if;
  logic       IN_VALID;
  logic       IN_READY;
  logic [2:0] OP;
  logic [4:0] ALU_OUT;
  logic       OUT_VALID;
  logic       OUT_READY;
  logic [2:0] OUT_OP;
  logic [4:0] OUT_DATA;
  logic       OUT_ZERO;
  logic       OUT_MSB;

  modport slave (
    input  IN_VALID, OP, ALU_OUT, OUT_READY,
    output IN_READY, OUT_VALID, OUT_OP,
    output OUT_DATA, OUT_ZERO, OUT_MSB
  );

  modport master (
    output IN_VALID, OP, ALU_OUT, OUT_READY,
    input  IN_READY, OUT_VALID, OUT_OP,
    input  OUT_DATA, OUT_ZERO, OUT_MSB
  );
endinterface

// File: rtl/alu_result_buffer.sv
// Show-ahead FIFO of tagged ALU results with
// occupancy, saturating push count and sticky stall flag.
module alu_result_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  alu_result_buffer_if.slave     bus,
  output logic [$clog2(DEPTH):0] COUNT,
  output logic [7:0]             TOTAL_CNT,
  output logic                   STALL_FLAG
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    total_q, total_d;
  logic          stall_q, stall_d;

  logic       in_ready;
  logic       out_valid;
  logic       push;
  logic       pop;
  logic [7:0] head;

  // Ready comes only from registered occupancy, so a
  // full buffer never accepts even while popping.
  assign in_ready  = count_q < CW'(DEPTH);
  assign out_valid = count_q != '0;
  assign push      = bus.IN_VALID & in_ready;
  assign pop       = out_valid & bus.OUT_READY;
  assign head      = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    total_d  = total_q;
    stall_d  = stall_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (push && total_q != 8'hFF)
      total_d = total_q + 8'd1;
    if (bus.IN_VALID && !in_ready)
      stall_d = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      total_q  <= '0;
      stall_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      total_q  <= total_d;
      stall_q  <= stall_d;
    end
  end

  // Storage is not reset; occupancy alone decides validity.
  always_ff @(posedge CLK) begin
    if (RST_N && push)
      mem_q[wr_ptr_q] <= {bus.OP, bus.ALU_OUT};
  end

  assign bus.IN_READY  = in_ready;
  assign bus.OUT_VALID = out_valid;
  assign bus.OUT_OP    = out_valid ? head[7:5] : 3'd0;
  assign bus.OUT_DATA  = out_valid ? head[4:0] : 5'd0;
  assign bus.OUT_ZERO  = out_valid && head[4:0] == 5'd0;
  assign bus.OUT_MSB   = out_valid && head[4];

  assign COUNT      = count_q;
  assign TOTAL_CNT  = total_q;
  assign STALL_FLAG = stall_q;
endmodule

// File: tb/tb_alu_result_buffer.sv
// Directed and random checks of alu_result_buffer
// against a queue-based reference model.
module tb_alu_result_buffer;
  localparam int DEPTH = 4;

  logic       CLK;
  logic       RST_N;
  logic [2:0] COUNT;
  logic [7:0] TOTAL_CNT;
  logic       STALL_FLAG;

  alu_result_buffer_if bus ();

  alu_result_buffer #(.DEPTH(DEPTH)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .bus       (bus.slave),
    .COUNT     (COUNT),
    .TOTAL_CNT (TOTAL_CNT),
    .STALL_FLAG(STALL_FLAG)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic [7:0] mq [$];
  int         m_total;
  bit         m_stall;
  bit         chk_en;
  int         errors;
  int         checks;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic check_model();
    logic [7:0] h;
    bit         v;
    v = mq.size() != 0;
    h = v ? mq[0] : 8'd0;
    check("in_ready", 32'(bus.IN_READY),
          32'(mq.size() < DEPTH));
    check("out_valid", 32'(bus.OUT_VALID), 32'(v));
    check("out_op", 32'(bus.OUT_OP), 32'(h[7:5]));
    check("out_data", 32'(bus.OUT_DATA), 32'(h[4:0]));
    check("out_zero", 32'(bus.OUT_ZERO),
          32'(v && h[4:0] == 5'd0));
    check("out_msb", 32'(bus.OUT_MSB), 32'(v && h[4]));
    check("count", 32'(COUNT), 32'(mq.size()));
    check("total", 32'(TOTAL_CNT), 32'(m_total));
    check("stall", 32'(STALL_FLAG), 32'(m_stall));
  endtask

  // One clock: drive, check pre-edge state, clock,
  // advance the model, return at the next negedge.
  task automatic cycle(input bit v, input logic [2:0] op,
                       input logic [4:0] d, input bit rdy,
                       input bit rst_n, output bit took);
    bit full, do_pop;
    bus.IN_VALID  = v;
    bus.OP        = op;
    bus.ALU_OUT   = d;
    bus.OUT_READY = rdy;
    RST_N         = rst_n;
    #1;
    if (chk_en) check_model();
    @(posedge CLK);
    full   = mq.size() >= DEPTH;
    do_pop = mq.size() != 0 && rdy;
    took   = 1'b0;
    if (!rst_n) begin
      mq.delete();
      m_total = 0;
      m_stall = 1'b0;
    end else begin
      if (v && full) m_stall = 1'b1;
      if (do_pop) void'(mq.pop_front());
      if (v && !full) begin
        mq.push_back({op, d});
        took = 1'b1;
        if (m_total < 255) m_total++;
      end
    end
    @(negedge CLK);
  endtask

  initial begin
    bit         t;
    logic [2:0] pop_;
    logic [4:0] pd;
    bit         pend;
    logic [4:0] fill_d [5];
    fill_d = '{5'd11, 5'd3, 5'd28, 5'd0, 5'd16};
    errors  = 0;
    checks  = 0;
    chk_en  = 1'b0;
    m_total = 0;
    m_stall = 1'b0;
    bus.IN_VALID  = 1'b0;
    bus.OP        = '0;
    bus.ALU_OUT   = '0;
    bus.OUT_READY = 1'b0;
    RST_N         = 1'b0;
    @(negedge CLK);
    cycle(0, 0, 0, 0, 0, t);
    chk_en = 1'b1;
    cycle(0, 0, 0, 0, 1, t);

    // single pass
    cycle(1, 3'd0, 5'b01011, 0, 1, t);
    check("single_valid", 32'(bus.OUT_VALID), 1);
    check("single_data", 32'(bus.OUT_DATA), 32'h0B);
    check("single_cnt", 32'(COUNT), 1);
    check("single_tot", 32'(TOTAL_CNT), 1);
    cycle(0, 0, 0, 1, 1, t);

    // fill past full, then drain and re-offer
    for (int i = 0; i < 5; i++)
      cycle(1, 3'(i), fill_d[i], 0, 1, t);
    check("fill_cnt", 32'(COUNT), 4);
    check("fill_rdy", 32'(bus.IN_READY), 0);
    check("fill_stall", 32'(STALL_FLAG), 1);
    for (int i = 0; i < 4; i++) begin
      check("drain_data", 32'(bus.OUT_DATA),
            32'(fill_d[i]));
      cycle(0, 0, 0, 1, 1, t);
    end
    cycle(1, 3'd4, 5'd16, 0, 1, t);
    check("reoffer_data", 32'(bus.OUT_DATA), 16);
    check("reoffer_msb", 32'(bus.OUT_MSB), 1);
    cycle(0, 0, 0, 1, 1, t);

    // concurrent push/pop across pointer wrap
    cycle(1, 3'd1, 5'd7, 0, 1, t);
    cycle(1, 3'd2, 5'd9, 0, 1, t);
    for (int i = 0; i < 6; i++)
      cycle(1, 3'($urandom), 5'($urandom), 1, 1, t);
    check("conc_cnt", 32'(COUNT), 2);

    // full with pop: pop only, then push next cycle
    cycle(1, 3'd5, 5'd1, 0, 1, t);
    cycle(1, 3'd6, 5'd2, 0, 1, t);
    check("full_cnt", 32'(COUNT), 4);
    cycle(1, 3'd7, 5'd3, 1, 1, t);
    check("fullpop_cnt", 32'(COUNT), 3);
    cycle(1, 3'd7, 5'd3, 0, 1, t);
    check("fullpush_cnt", 32'(COUNT), 4);

    // reset mid-stream with a coincident push
    cycle(0, 0, 0, 1, 1, t);
    check("pre_rst_cnt", 32'(COUNT), 3);
    cycle(1, 3'd3, 5'd5, 1, 0, t);
    check("rst_cnt", 32'(COUNT), 0);
    check("rst_valid", 32'(bus.OUT_VALID), 0);
    check("rst_tot", 32'(TOTAL_CNT), 0);
    check("rst_stall", 32'(STALL_FLAG), 0);
    cycle(1, 3'd6, 5'd21, 0, 1, t);
    check("post_rst_op", 32'(bus.OUT_OP), 6);
    check("post_rst_data", 32'(bus.OUT_DATA), 21);
    cycle(0, 0, 0, 1, 1, t);

    // saturation of the accepted-result counter
    cycle(1, 3'd0, 5'd1, 0, 1, t);
    for (int i = 0; i < 300; i++)
      cycle(1, 3'($urandom), 5'($urandom), 1, 1, t);
    check("sat_tot", 32'(TOTAL_CNT), 255);
    check("sat_cnt", 32'(COUNT), 1);

    // random traffic; upstream holds a refused result
    pend = 1'b0;
    pop_ = '0;
    pd   = '0;
    for (int i = 0; i < 600; i++) begin
      if (!pend && $urandom_range(0, 2) != 0) begin
        pend = 1'b1;
        pop_ = 3'($urandom);
        pd   = 5'($urandom);
      end
      cycle(pend, pop_, pd, 1'($urandom),
            $urandom_range(0, 63) != 0, t);
      if (t || !RST_N) pend = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end
endmodule
